// File: rtl/helios_host_pkg.sv
// Shared message codes, controller state encoding and frame geometry helper
// for the Helios host-side framing logic.
`timescale 1ns/1ps
package helios_host_pkg;

    localparam logic [7:0] START_DECODING_MSG      = 8'h01;
    localparam logic [7:0] MEASUREMENT_DATA_HEADER = 8'h02;
    localparam logic [7:0] PROTOCOL_ERROR_MSG      = 8'hEE;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HDR,
        LOAD,
        HANDOFF,
        DECODE,
        REPORT,
        ERROR
    } state_t;

    function automatic int bytes_per_round(input int pu_per_round);
        return (pu_per_round + 7) >>> 3;
    endfunction

endpackage

// File: rtl/frame_report_serializer.sv
// Holds up to five message bytes (byte 0 in load_bytes[7:0]) and shifts them
// out one per out_valid/out_ready handshake; out_data is stable while stalled.
`timescale 1ns/1ps
module frame_report_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [39:0] load_bytes,
    input  logic [2:0]  load_len,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        last_byte
);

    logic [31:0] pending;
    logic [2:0]  remaining;

    // High while the byte on out_data is the final one of the message.
    assign last_byte = (remaining == 3'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            pending   <= 32'h0;
            remaining <= 3'd0;
        end else if (load) begin
            out_data  <= load_bytes[7:0];
            pending   <= load_bytes[39:8];
            remaining <= load_len;
            out_valid <= (load_len != 3'd0);
        end else if (out_valid && out_ready) begin
            if (remaining == 3'd1) begin
                out_valid <= 1'b0;
                remaining <= 3'd0;
            end else begin
                out_data  <= pending[7:0];
                pending   <= {8'h00, pending[31:8]};
                remaining <= remaining - 3'd1;
            end
        end
    end

endmodule

// File: rtl/syndrome_frame_controller.sv
// Host framing controller: parses START/header/payload beats into a measurement
// frame, times the decode and reports iter/cycles (plus popcount with SYNDROME_COUNT_EN).
`timescale 1ns/1ps
module syndrome_frame_controller
    import helios_host_pkg::*;
#(
    parameter int BEAT_BYTES   = 1,
    parameter int PU_PER_ROUND = 32,
    parameter int ROUNDS       = 7,
    parameter int ITER_WIDTH   = 8
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [8*BEAT_BYTES-1:0]                       in_data,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [7:0]                                    out_data,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [8*bytes_per_round(PU_PER_ROUND)*ROUNDS-1:0] measurements,
    output logic                                          meas_valid,
    input  logic                                          meas_ready,
    input  logic                                          result_valid,
    input  logic [ITER_WIDTH-1:0]                         result_iter,
    output logic                                          result_ready
);

    localparam int BPR         = bytes_per_round(PU_PER_ROUND);
    localparam int TOTAL_BYTES = BPR * ROUNDS;
    localparam int MASK_W      = 8 * (TOTAL_BYTES + 2 * BEAT_BYTES);
    localparam int PTR_W       = $clog2(TOTAL_BYTES + 2 * BEAT_BYTES + 1);
`ifdef SYNDROME_COUNT_EN
    localparam logic [2:0] REPORT_LEN = 3'd5;
`else
    localparam logic [2:0] REPORT_LEN = 3'd3;
`endif

    // Valid-bit mask per frame byte; padded with zero bytes so lanes that run
    // past the end of the frame read a zero mask.
    function automatic logic [MASK_W-1:0] build_mask();
        logic [MASK_W-1:0] m;
        m = '0;
        for (int k = 0; k < ROUNDS; k++)
            for (int i = 0; i < PU_PER_ROUND; i++)
                m[k*8*BPR + i] = 1'b1;
        return m;
    endfunction

    localparam logic [MASK_W-1:0] MEAS_MASK = build_mask();

    state_t                  state;
    logic [PTR_W-1:0]        byte_ptr;
    logic [15:0]             cyc_cnt;
    logic [8*BEAT_BYTES-1:0] lane_data;
    logic [7:0]              lane0;
    logic [7:0]              iter_lo;
    logic [15:0]             syn_count;
    logic                    accept;
    logic                    ser_load;
    logic [39:0]             ser_bytes;
    logic [2:0]              ser_len;
    logic                    ser_last;
    logic                    ser_done;

    assign lane0    = in_data[7:0];
    assign accept   = in_valid && in_ready;
    assign ser_done = out_valid && out_ready && ser_last;

    for (genvar g = 0; g < BEAT_BYTES; g++) begin : g_lane
        assign lane_data[g*8 +: 8] = in_data[g*8 +: 8] & MEAS_MASK[(32'(byte_ptr) + g)*8 +: 8];
    end

    if (ITER_WIDTH >= 8) begin : g_iter_wide
        assign iter_lo = result_iter[7:0];
    end else begin : g_iter_narrow
        assign iter_lo = 8'(result_iter);
    end

`ifdef SYNDROME_COUNT_EN
    always_ff @(posedge clk) begin
        if (!reset)
            syn_count <= 16'h0;
        else if (state == WAIT_HDR && accept && lane0 == MEASUREMENT_DATA_HEADER)
            syn_count <= 16'h0;
        else if (state == LOAD && accept)
            syn_count <= syn_count + 16'($countones(lane_data));
    end
`else
    assign syn_count = 16'h0;
`endif

    // The serializer captures the report bytes, so iter and cyc need no
    // separate holding registers.
    always_comb begin
        ser_load  = 1'b0;
        ser_bytes = 40'h0;
        ser_len   = 3'd0;
        if (state == WAIT_HDR && accept && lane0 != MEASUREMENT_DATA_HEADER &&
            lane0 != START_DECODING_MSG) begin
            ser_load  = 1'b1;
            ser_bytes = {32'h0, PROTOCOL_ERROR_MSG};
            ser_len   = 3'd1;
        end else if (state == DECODE && result_valid && result_ready) begin
            ser_load  = 1'b1;
            ser_bytes = {syn_count[7:0], syn_count[15:8], cyc_cnt[7:0], cyc_cnt[15:8], iter_lo};
            ser_len   = REPORT_LEN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            in_ready     <= 1'b0;
            meas_valid   <= 1'b0;
            result_ready <= 1'b0;
            measurements <= '0;
            byte_ptr     <= '0;
            cyc_cnt      <= 16'h0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept && lane0 == START_DECODING_MSG)
                        state <= WAIT_HDR;
                end
                WAIT_HDR: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        if (lane0 == MEASUREMENT_DATA_HEADER) begin
                            state        <= LOAD;
                            byte_ptr     <= '0;
                            measurements <= '0;
                        end else if (lane0 != START_DECODING_MSG) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        for (int l = 0; l < BEAT_BYTES; l++)
                            if (32'(byte_ptr) + l < TOTAL_BYTES)
                                measurements[(32'(byte_ptr) + l)*8 +: 8] <= lane_data[l*8 +: 8];
                        byte_ptr <= byte_ptr + PTR_W'(BEAT_BYTES);
                        if (32'(byte_ptr) + BEAT_BYTES >= TOTAL_BYTES) begin
                            state      <= HANDOFF;
                            in_ready   <= 1'b0;
                            meas_valid <= 1'b1;
                        end
                    end
                end
                HANDOFF: begin
                    if (meas_valid && meas_ready) begin
                        meas_valid   <= 1'b0;
                        cyc_cnt      <= 16'h0;
                        result_ready <= 1'b1;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    if (result_valid) begin
                        result_ready <= 1'b0;
                        state        <= REPORT;
                    end else if (cyc_cnt != 16'hFFFF) begin
                        cyc_cnt <= cyc_cnt + 16'h1;
                    end
                end
                REPORT, ERROR: begin
                    if (ser_done) begin
                        state    <= WAIT_HDR;
                        in_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    frame_report_serializer u_serializer (
        .clk        (clk),
        .reset      (reset),
        .load       (ser_load),
        .load_bytes (ser_bytes),
        .load_len   (ser_len),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .last_byte  (ser_last)
    );

endmodule

// File: tb/tb_syndrome_frame_controller.sv
// Directed bench for syndrome_frame_controller with 4-byte beats and the
// default 7 x 32-bit frame; report length follows SYNDROME_COUNT_EN.
`timescale 1ns/1ps
module tb_syndrome_frame_controller;

  localparam int MW = 224;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [31:0]   in_data = 32'h0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [MW-1:0] measurements;
  logic          meas_valid;
  logic          meas_ready = 1'b0;
  logic          result_valid = 1'b0;
  logic [7:0]    result_iter = 8'h0;
  logic          result_ready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  syndrome_frame_controller #(
    .BEAT_BYTES(4), .PU_PER_ROUND(32), .ROUNDS(7), .ITER_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .measurements(measurements), .meas_valid(meas_valid), .meas_ready(meas_ready),
    .result_valid(result_valid), .result_iter(result_iter), .result_ready(result_ready)
  );

  always @(negedge clk) begin
    if (reset && in_ready && out_valid) begin
      failures++;
      $display("FAIL in_out_exclusive in_ready=%b out_valid=%b required not both 1", in_ready, out_valid);
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [MW-1:0] ramp(input logic [7:0] xv);
    logic [MW-1:0] r;
    for (int n = 0; n < 28; n++) r[n*8 +: 8] = 8'(n) ^ xv;
    return r;
  endfunction

  task automatic send_beat(input logic [31:0] d);
    int n;
    n = 0;
    in_data = d;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL send_beat_timeout in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_payload(input logic [MW-1:0] v, input string name);
    for (int j = 0; j < 6; j++) send_beat(v[j*32 +: 32]);
    checks++;
    if (meas_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_pre_last meas_valid=%b in_ready=%b required 0 1", name, meas_valid, in_ready);
    end
    send_beat(v[6*32 +: 32]);
    checks++;
    if (meas_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s_meas_valid meas_valid=%b in_ready=%b required 1 0", name, meas_valid, in_ready);
    end
    checks++;
    if (measurements !== v) begin
      failures++;
      $display("FAIL %s_meas got %h required %h", name, measurements, v);
    end
  endtask

  task automatic get_byte(output logic [7:0] b, output bit ok);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (out_valid === 1'b1);
    b = out_data;
    @(posedge clk); #1;
  endtask

  task automatic do_decode(input int delay, input logic [7:0] iter, input bit hold,
                           input logic [MW-1:0] exp_meas);
    bit bad;
    if (hold) begin
      bad = 1'b0;
      repeat (5) begin
        @(posedge clk); #1;
        if (meas_valid !== 1'b1 || measurements !== exp_meas || result_ready !== 1'b0 || in_ready !== 1'b0)
          bad = 1'b1;
      end
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL handoff_hold meas_valid=%b result_ready=%b in_ready=%b required 1 0 0 with stable frame",
                 meas_valid, result_ready, in_ready);
      end
    end
    meas_ready = 1'b1;
    @(posedge clk); #1;
    meas_ready = 1'b0;
    checks++;
    if (meas_valid !== 1'b0 || result_ready !== 1'b1) begin
      failures++;
      $display("FAIL decode_entry meas_valid=%b result_ready=%b required 0 1", meas_valid, result_ready);
    end
    result_iter = iter;
    repeat (delay) @(posedge clk);
    if (delay > 0) #1;
    result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid = 1'b0;
    checks++;
    if (result_ready !== 1'b0) begin
      failures++;
      $display("FAIL decode_exit result_ready=%b required 0", result_ready);
    end
  endtask

  task automatic check_report(input string name, input logic [7:0] iter, input logic [15:0] cyc,
                              input logic [15:0] cnt, input bit stall);
    logic [7:0] exp_b [5];
    logic [7:0] b;
    bit ok;
    bit bad;
    int len;
    exp_b = '{iter, cyc[15:8], cyc[7:0], cnt[15:8], cnt[7:0]};
`ifdef SYNDROME_COUNT_EN
    len = 5;
`else
    len = 3;
`endif
    for (int i = 0; i < len; i++) begin
      if (stall && i == 1) begin
        out_ready = 1'b0;
        bad = 1'b0;
        repeat (10) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b1 || out_data !== exp_b[1]) bad = 1'b1;
        end
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL %s_stall out_valid=%b out_data=%h required 1 %h", name, out_valid, out_data, exp_b[1]);
        end
      end
      get_byte(b, ok);
      checks++;
      if (!ok || b !== exp_b[i]) begin
        failures++;
        $display("FAIL %s_byte%0d got %h (valid=%b) required %h", name, i, b, ok, exp_b[i]);
      end
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_end out_valid=%b in_ready=%b required 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 ||
        meas_valid !== 1'b0 || result_ready !== 1'b0 || measurements !== '0) begin
      failures++;
      $display("FAIL %s in_ready=%b out_valid=%b out_data=%h meas_valid=%b result_ready=%b meas_nonzero=%b required all 0",
               name, in_ready, out_valid, out_data, meas_valid, result_ready, |measurements);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_idle_drop();
    send_beat(32'h0000_0055);
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_drop in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_frame_and_report();
    logic [MW-1:0] v;
    v = ramp(8'h00);
    send_beat(32'h0000_0001);
    send_beat(32'h0000_0002);
    send_payload(v, "ramp_frame");
    do_decode(300, 8'h09, 1'b1, v);
    check_report("report300", 8'h09, 16'd300, 16'($countones(v)), 1'b1);
  endtask

  task automatic test_error_then_frame();
    logic [MW-1:0] v;
    logic [7:0] b;
    bit ok;
    v = ramp(8'hA5);
    send_beat(32'hAABB_CC55);
    get_byte(b, ok);
    checks++;
    if (!ok || b !== 8'hEE) begin
      failures++;
      $display("FAIL error_byte got %h (valid=%b) required ee", b, ok);
    end
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL error_single out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    send_beat(32'h0000_0001);
    send_beat(32'hFFFF_FF02);
    send_payload(v, "after_error");
    do_decode(0, 8'h37, 1'b0, v);
    check_report("report0", 8'h37, 16'd0, 16'($countones(v)), 1'b0);
  endtask

  task automatic test_reset_mid_load();
    logic [MW-1:0] v;
    v = ramp(8'h5A);
    send_beat(32'h0000_0002);
    for (int j = 0; j < 3; j++) send_beat(v[j*32 +: 32]);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_mid_load");
    reset = 1'b1;
    @(posedge clk); #1;
    test_idle_drop();
    v = ramp(8'h3C);
    send_beat(32'h0000_0001);
    send_beat(32'h0000_0002);
    send_payload(v, "post_reset_frame");
    do_decode(5, 8'h80, 1'b0, v);
    check_report("report5", 8'h80, 16'd5, 16'($countones(v)), 1'b0);
  endtask

  task automatic test_saturation();
    logic [MW-1:0] v;
    v = '1;
    send_beat(32'h0000_0002);
    send_payload(v, "all_ones");
    do_decode(70000, 8'h42, 1'b0, v);
    check_report("report_sat", 8'h42, 16'hFFFF, 16'd224, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_drop();
    test_frame_and_report();
    test_error_then_frame();
    test_reset_mid_load();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
